// File: rtl/irq_controller_pkg.sv
// Shared definitions for the eight-source interrupt controller:
// FSM state encoding and source/index widths.
package irq_controller_pkg;

    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Priority encoder: reports the highest set index of in, with valid when any bit is set.
module irq_controller_prio_enc
    import irq_controller_pkg::*;
(
    input  logic [NUM_SRC-1:0] in,
    output logic [ID_W-1:0]    out,
    output logic               valid
);

    // Ascending scan so the last match, the highest index, wins.
    always_comb begin
        out   = '0;
        valid = |in;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in[i]) begin
                out = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Eight-source interrupt controller: rising-edge capture into pending, mask,
// and a single-outstanding irq/ack/eoi handshake toward one consumer.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter logic [NUM_SRC-1:0] RESET_MASK = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               ack,
    input  logic               eoi,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    state_e             state, state_n;
    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] req_edge;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] pend_clr;
    logic [ID_W-1:0]    enc_id;
    logic [ID_W-1:0]    id_n;
    logic               enc_valid;

    assign req_edge = req & ~req_q;
    assign eligible = pending & ~mask;

    irq_controller_prio_enc u_prio_enc (
        .in    (eligible),
        .out   (enc_id),
        .valid (enc_valid)
    );

    always_comb begin
        state_n  = state;
        id_n     = irq_id;
        pend_clr = '0;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_n = REQ;
                    id_n    = enc_id;
                end
            end
            REQ: begin
                // Presented source is locked in: no preemption, no withdrawal.
                if (ack) begin
                    state_n          = SERVICE;
                    pend_clr[irq_id] = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A new edge on the bit being acknowledged re-arms it (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= '0;
            pending <= '0;
            mask    <= RESET_MASK;
            irq_id  <= '0;
            irq     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            req_q   <= req;
            pending <= (pending & ~pend_clr) | req_edge;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            irq_id  <= id_n;
            irq     <= (state_n == REQ);
            busy    <= (state_n == SERVICE);
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: vector table through a scoreboard
// queue, then a hand-written asynchronous reset sequence.
module tb_irq_controller;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] pending;
    logic [7:0] mask;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [7:0] req;
        logic       mwe;
        logic [7:0] mwd;
        logic       ack;
        logic       eoi;
        logic       eirq;
        logic [2:0] eid;
        logic       ebusy;
        logic [7:0] epend;
        logic [7:0] emask;
    } vec_t;

    typedef struct {
        logic       eirq;
        logic [2:0] eid;
        logic       ebusy;
        logic [7:0] epend;
        logic [7:0] emask;
        int         row;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    irq_controller #(.RESET_MASK(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .eoi        (eoi),
        .irq        (irq),
        .irq_id     (irq_id),
        .busy       (busy),
        .pending    (pending),
        .mask       (mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic [7:0] r, input logic mwe, input logic [7:0] mwd,
                       input logic a, input logic e, input logic xirq, input logic [2:0] xid,
                       input logic xbusy, input logic [7:0] xpend, input logic [7:0] xmask);
        vec_t v;
        v.req = r; v.mwe = mwe; v.mwd = mwd; v.ack = a; v.eoi = e;
        v.eirq = xirq; v.eid = xid; v.ebusy = xbusy; v.epend = xpend; v.emask = xmask;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, push its expectation, sample 1ns after the edge.
    task automatic step(input vec_t v, input int row);
        exp_t e;
        exp_t got;
        req        = v.req;
        mask_we    = v.mwe;
        mask_wdata = v.mwd;
        ack        = v.ack;
        eoi        = v.eoi;
        e.eirq = v.eirq; e.eid = v.eid; e.ebusy = v.ebusy;
        e.epend = v.epend; e.emask = v.emask; e.row = row;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk($sformatf("row%0d_irq", got.row),     {31'd0, irq},     {31'd0, got.eirq});
            chk($sformatf("row%0d_irq_id", got.row),  {29'd0, irq_id},  {29'd0, got.eid});
            chk($sformatf("row%0d_busy", got.row),    {31'd0, busy},    {31'd0, got.ebusy});
            chk($sformatf("row%0d_pending", got.row), {24'd0, pending}, {24'd0, got.epend});
            chk($sformatf("row%0d_mask", got.row),    {24'd0, mask},    {24'd0, got.emask});
        end
    endtask

    task automatic quick(input logic [7:0] r, input logic mwe, input logic [7:0] mwd,
                         input logic a, input logic e, input logic xirq, input logic [2:0] xid,
                         input logic xbusy, input logic [7:0] xpend, input logic [7:0] xmask,
                         input int row);
        vec_t v;
        v.req = r; v.mwe = mwe; v.mwd = mwd; v.ack = a; v.eoi = e;
        v.eirq = xirq; v.eid = xid; v.ebusy = xbusy; v.epend = xpend; v.emask = xmask;
        step(v, row);
    endtask

    initial begin
        rst = 1'b1; req = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;

        //    req    mwe mwd    ack eoi | irq id busy pend   mask
        // masked rise, then unmask and service source 0
        add(8'h01, 0, 8'h00, 0, 0,   0, 0, 0, 8'h01, 8'hFF);
        add(8'h01, 0, 8'h00, 0, 0,   0, 0, 0, 8'h01, 8'hFF);
        add(8'h00, 1, 8'h00, 0, 0,   0, 0, 0, 8'h01, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,   1, 0, 0, 8'h01, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 8'h00);
        // priority: 5 before 2
        add(8'h24, 0, 8'h00, 0, 0,   0, 0, 0, 8'h24, 8'h00);
        add(8'h24, 0, 8'h00, 0, 0,   1, 5, 0, 8'h24, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,   0, 5, 1, 8'h04, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,   0, 5, 0, 8'h04, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,   1, 2, 0, 8'h04, 8'h00);
        // no preemption by source 7
        add(8'h80, 0, 8'h00, 0, 0,   1, 2, 0, 8'h84, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,   1, 2, 0, 8'h84, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,   0, 2, 1, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,   0, 2, 0, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,   1, 7, 0, 8'h80, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,   0, 7, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,   0, 7, 0, 8'h00, 8'h00);
        // set/clear collision on source 3
        add(8'h08, 0, 8'h00, 0, 0,   0, 7, 0, 8'h08, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,   1, 3, 0, 8'h08, 8'h00);
        add(8'h08, 0, 8'h00, 1, 0,   0, 3, 1, 8'h08, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,   0, 3, 0, 8'h08, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,   1, 3, 0, 8'h08, 8'h00);
        add(8'h00, 0, 8'h00, 1, 0,   0, 3, 1, 8'h00, 8'h00);
        // stray ack in SERVICE, stray eoi in IDLE
        add(8'h00, 0, 8'h00, 1, 0,   0, 3, 1, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,   0, 3, 0, 8'h00, 8'h00);
        add(8'h00, 0, 8'h00, 0, 1,   0, 3, 0, 8'h00, 8'h00);
        // mask dynamics on source 4
        add(8'h00, 1, 8'h10, 0, 0,   0, 3, 0, 8'h00, 8'h10);
        add(8'h10, 0, 8'h00, 0, 0,   0, 3, 0, 8'h10, 8'h10);
        add(8'h00, 0, 8'h00, 0, 0,   0, 3, 0, 8'h10, 8'h10);
        add(8'h00, 0, 8'h00, 0, 0,   0, 3, 0, 8'h10, 8'h10);
        add(8'h00, 1, 8'h00, 0, 0,   0, 3, 0, 8'h10, 8'h00);
        add(8'h00, 0, 8'h00, 0, 0,   1, 4, 0, 8'h10, 8'h00);
        // masking while in REQ does not withdraw; ack+eoi together takes ack
        add(8'h00, 1, 8'hFF, 0, 0,   1, 4, 0, 8'h10, 8'hFF);
        add(8'h00, 0, 8'h00, 1, 1,   0, 4, 1, 8'h00, 8'hFF);
        add(8'h00, 0, 8'h00, 0, 1,   0, 4, 0, 8'h00, 8'hFF);
        add(8'h00, 1, 8'h00, 0, 0,   0, 4, 0, 8'h00, 8'h00);

        #12;
        chk("reset_irq",     {31'd0, irq},     32'd0);
        chk("reset_irq_id",  {29'd0, irq_id},  32'd0);
        chk("reset_busy",    {31'd0, busy},    32'd0);
        chk("reset_pending", {24'd0, pending}, 32'h00);
        chk("reset_mask",    {24'd0, mask},    32'hFF);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Enter SERVICE for source 1 with source 0 also pending.
        quick(8'h02, 0, 8'h00, 0, 0,  0, 4, 0, 8'h02, 8'h00, 100);
        quick(8'h00, 0, 8'h00, 0, 0,  1, 1, 0, 8'h02, 8'h00, 101);
        quick(8'h00, 0, 8'h00, 1, 0,  0, 1, 1, 8'h00, 8'h00, 102);
        quick(8'h01, 0, 8'h00, 0, 0,  0, 1, 1, 8'h01, 8'h00, 103);

        // Asynchronous reset between edges must clear state with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy",    {31'd0, busy},    32'd0);
        chk("async_rst_irq",     {31'd0, irq},     32'd0);
        chk("async_rst_pending", {24'd0, pending}, 32'h00);
        chk("async_rst_mask",    {24'd0, mask},    32'hFF);
        chk("async_rst_irq_id",  {29'd0, irq_id},  32'd0);
        @(posedge clk);
        #1;
        chk("held_rst_pending", {24'd0, pending}, 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // req[0] still high at release counts as an edge on the first clock.
        quick(8'h01, 1, 8'h00, 0, 0,  0, 0, 0, 8'h01, 8'h00, 200);
        quick(8'h01, 0, 8'h00, 0, 0,  1, 0, 0, 8'h01, 8'h00, 201);
        quick(8'h01, 0, 8'h00, 1, 0,  0, 0, 1, 8'h00, 8'h00, 202);

        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
